// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Read-side consumer of the AHB-to-SPI async FIFO, in the SPI clock domain. Pops 41-bit
//   command words {rw, addr, wdata} and sends each as one SPI mode-0 frame, MSB first.
//   Read commands (rw=0) return the last DATA_BITS MISO samples as a one-cycle response.
// Ports
//   clk, rst_n     SPI-domain clock (same as FIFO rd_clk), async active-low reset
//   fifo_empty     FIFO empty flag
//   fifo_rd_en     FIFO pop strobe (only in IDLE and only when not empty)
//   fifo_rd_data   FIFO read data, valid the cycle after fifo_rd_en
//   sclk/cs_n/mosi SPI outputs (CPOL=0, CPHA=0)
//   miso           SPI input, sampled on the SCLK rising edge
//   busy           high whenever the FSM is not idle
//   rd_resp_valid  one-cycle pulse when read data is ready
//   rd_resp_data   captured read data, held until the next read completes
module spi_master_ctrl #(
   parameter int unsigned DATA_WIDTH = 41,
   parameter int unsigned ADDR_BITS  = 8,
   parameter int unsigned DATA_BITS  = 32,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned CS_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  busy,
   output logic                  rd_resp_valid,
   output logic [DATA_BITS-1:0]  rd_resp_data
);

   // Bits per frame; equals DATA_WIDTH in any legal configuration.
   localparam int unsigned WordW = 1 + ADDR_BITS + DATA_BITS;
   localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GapW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int unsigned BitW  = $clog2(WordW + 1);

   typedef enum logic [2:0] {StIdle, StPop, StLoad, StXfer, StGap} state_e;

   state_e                state_q, state_d;
   logic [DivW-1:0]       div_q, div_d;
   logic [GapW-1:0]       gap_q, gap_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic                  sclk_q, sclk_d;
   logic                  rw_q, rw_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0]  cap_q, cap_d;
   logic [DATA_BITS-1:0]  resp_data_q, resp_data_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  div_tick;

   assign div_tick = (div_q == DivW'(CLK_DIV - 1));

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      gap_d        = gap_q;
      bit_d        = bit_q;
      sclk_d       = sclk_q;
      rw_d         = rw_q;
      shift_d      = shift_q;
      cap_d        = cap_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) state_d = StPop;
         end
         StPop: begin
            state_d = StLoad;
         end
         StLoad: begin
            shift_d = fifo_rd_data;
            rw_d    = fifo_rd_data[DATA_WIDTH-1];
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            state_d = StXfer;
         end
         StXfer: begin
            if (div_tick) begin
               div_d  = '0;
               sclk_d = !sclk_q;
               if (!sclk_q) begin
                  // Rising edge: older samples fall off the top, leaving the last DATA_BITS.
                  cap_d = {cap_q[DATA_BITS-2:0], miso};
               end else begin
                  shift_d = shift_q << 1;
                  bit_d   = bit_q + BitW'(1);
                  if (bit_q == BitW'(WordW - 1)) begin
                     state_d = StGap;
                     gap_d   = '0;
                     if (!rw_q) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = cap_q;
                     end
                  end
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StGap: begin
            if (gap_q == GapW'(CS_GAP - 1)) state_d = StIdle;
            else gap_d = gap_q + GapW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         div_q        <= '0;
         gap_q        <= '0;
         bit_q        <= '0;
         sclk_q       <= 1'b0;
         rw_q         <= 1'b0;
         shift_q      <= '0;
         cap_q        <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         gap_q        <= gap_d;
         bit_q        <= bit_d;
         sclk_q       <= sclk_d;
         rw_q         <= rw_d;
         shift_q      <= shift_d;
         cap_q        <= cap_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // rst_n gating keeps the pop strobe low while reset holds the FSM in IDLE.
   assign fifo_rd_en    = rst_n && (state_q == StIdle) && !fifo_empty;
   // cs_n and the first MOSI bit come straight from LOAD so the frame starts on that cycle.
   assign cs_n          = !((state_q == StLoad) || (state_q == StXfer));
   assign mosi          = (state_q == StLoad) ? fifo_rd_data[DATA_WIDTH-1] :
                          (state_q == StXfer) ? shift_q[DATA_WIDTH-1] : 1'b0;
   assign sclk          = sclk_q;
   assign busy          = (state_q != StIdle);
   assign rd_resp_valid = resp_valid_q;
   assign rd_resp_data  = resp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1), each fed by a FIFO model
// and an SPI slave model. Stimulus pushes the expected MOSI word and read response into
// queues; negedge monitors decode the SPI lines and check against those queues.
module tb_spi_master_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: event missing at %0t", name, $time);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_ch
      localparam int unsigned CD  = (g == 0) ? 2 : 1;
      localparam int unsigned GAP = 2;

      logic        fe = 1'b1;
      logic        miso = 1'b0;
      logic [40:0] rdd = '0;
      logic        rd_en, sclk, cs_n, mosi, busy, rv;
      logic [31:0] rdat;

      logic [40:0] fq[$];     // FIFO contents
      logic [40:0] exp_q[$];  // expected MOSI word per frame
      logic [40:0] pat_q[$];  // MISO pattern per frame
      logic [31:0] rq[$];     // expected read responses
      int pushes = 0;
      int pops = 0;

      spi_master_ctrl #(
         .CLK_DIV (CD),
         .CS_GAP  (GAP)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .fifo_empty    (fe),
         .fifo_rd_en    (rd_en),
         .fifo_rd_data  (rdd),
         .sclk          (sclk),
         .cs_n          (cs_n),
         .mosi          (mosi),
         .miso          (miso),
         .busy          (busy),
         .rd_resp_valid (rv),
         .rd_resp_data  (rdat)
      );

      // FIFO model: registered read data, one cycle after the pop strobe.
      always @(posedge clk) begin
         if (rd_en) begin
            pops++;
            if (fq.size() == 0) fail_now("fifo_underflow");
            else rdd <= fq.pop_front();
         end
      end

      logic        prev_cs = 1'b1;
      logic        prev_sclk = 1'b0;
      bit          seen_frame = 1'b0;
      int          k, lowcnt, rises, since_rise, hicnt;
      logic [40:0] rx, pat, e;

      always @(negedge clk) begin
         fe = (fq.size() == 0);
         if (!rst_n) begin
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            seen_frame = 1'b0;
            hicnt      = 0;
            miso       = 1'b0;
         end else begin
            if (rd_en) chk("pop_when_empty", fe, 0);
            if (cs_n) begin
               chk("mosi_idle", mosi, 0);
               chk("sclk_idle", sclk, 0);
            end
            if (prev_cs && !cs_n) begin
               if (seen_frame) chk("cs_high_gap_ok", (hicnt >= GAP + 2), 1);
               if (pat_q.size() == 0) begin
                  fail_now("unexpected_frame");
                  pat = '0;
               end else begin
                  pat = pat_q.pop_front();
               end
               k          = 0;
               miso       = pat[40];
               lowcnt     = 0;
               rises      = 0;
               rx         = '0;
               since_rise = 0;
            end
            if (!cs_n) begin
               lowcnt++;
               since_rise++;
               if (!prev_sclk && sclk) begin
                  rx = {rx[39:0], mosi};
                  if (rises > 0) chk("sclk_period", since_rise, 2 * CD);
                  rises++;
                  since_rise = 0;
               end
               if (prev_sclk && !sclk) begin
                  k++;
                  if (k <= 40) miso = pat[40-k];
               end
            end
            if (!prev_cs && cs_n) begin
               seen_frame = 1'b1;
               hicnt      = 0;
               miso       = 1'b0;
               if (exp_q.size() == 0) begin
                  fail_now("unexpected_frame_end");
               end else begin
                  e = exp_q.pop_front();
                  chk("mosi_word", rx, e);
               end
               chk("sclk_rises", rises, 41);
               chk("cs_low_cycles", lowcnt, 1 + 82 * CD);
            end
            if (cs_n) hicnt++;
            if (rv) begin
               if (rq.size() == 0) fail_now("unexpected_rd_resp");
               else chk("rd_resp_data", rdat, rq.pop_front());
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
         end
      end
   end

   // Reference: MOSI carries the word MSB first; a read returns the last 32 MISO bits,
   // which for a 41-bit MSB-first pattern are pattern[31:0].
   task automatic push(input int ch, input logic [40:0] w, input logic [40:0] p);
      if (ch == 0) begin
         g_ch[0].fq.push_back(w);
         g_ch[0].exp_q.push_back(w);
         g_ch[0].pat_q.push_back(p);
         if (!w[40]) g_ch[0].rq.push_back(p[31:0]);
         g_ch[0].pushes++;
      end else begin
         g_ch[1].fq.push_back(w);
         g_ch[1].exp_q.push_back(w);
         g_ch[1].pat_q.push_back(p);
         if (!w[40]) g_ch[1].rq.push_back(p[31:0]);
         g_ch[1].pushes++;
      end
   endtask

   function automatic logic [40:0] rnd41();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[40:0];
   endfunction

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk);
         done = (g_ch[0].fq.size() == 0) && (g_ch[0].exp_q.size() == 0) &&
                (g_ch[0].rq.size() == 0) && !g_ch[0].busy &&
                (g_ch[1].fq.size() == 0) && (g_ch[1].exp_q.size() == 0) &&
                (g_ch[1].rq.size() == 0) && !g_ch[1].busy;
      end
      if (!done) fail_now(name);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cs_n0"}, g_ch[0].cs_n, 1);
      chk({tag, "_sclk0"}, g_ch[0].sclk, 0);
      chk({tag, "_busy0"}, g_ch[0].busy, 0);
      chk({tag, "_rd_en0"}, g_ch[0].rd_en, 0);
      chk({tag, "_mosi0"}, g_ch[0].mosi, 0);
      chk({tag, "_rv0"}, g_ch[0].rv, 0);
   endtask

   initial begin
      logic [40:0] w;
      logic [40:0] p;
      bit          hit;

      // Reset values
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      chk("reset_rdat0", g_ch[0].rdat, 0);
      chk("reset_cs_n1", g_ch[1].cs_n, 1);
      chk("reset_busy1", g_ch[1].busy, 0);
      chk("reset_rdat1", g_ch[1].rdat, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Directed write, then directed read returning CAFEF00D
      push(0, 41'h1_A5_DEADBEEF, rnd41());
      p = rnd41();
      p[31:0] = 32'hCAFEF00D;
      push(0, {1'b0, 8'h3C, 32'h0}, p);
      wait_drain("drain_directed");
      chk("rdat_hold_cafef00d", g_ch[0].rdat, 32'hCAFEF00D);

      // Back-to-back: three words preloaded together
      for (int i = 0; i < 3; i++) push(0, rnd41(), rnd41());
      wait_drain("drain_b2b");
      chk("b2b_pops", g_ch[0].pops, g_ch[0].pushes);

      // Empty FIFO for 100 cycles
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("empty_rd_en", g_ch[0].rd_en, 0);
         chk("empty_cs_n", g_ch[0].cs_n, 1);
         chk("empty_busy", g_ch[0].busy, 0);
      end

      // CLK_DIV=1 instance: directed word with LSB set, then a few random ones
      push(1, 41'h0_00_00000001, rnd41());
      for (int i = 0; i < 3; i++) push(1, rnd41(), rnd41());
      wait_drain("drain_div1");

      // Random traffic with random spacing
      for (int i = 0; i < 16; i++) begin
         push(0, rnd41(), rnd41());
         repeat ($urandom_range(0, 200)) @(negedge clk);
      end
      wait_drain("drain_random");

      // Reset mid-XFER: a write in flight is dropped, the queued read completes afterwards
      w = rnd41();
      w[40] = 1'b1;
      push(0, w, rnd41());
      push(0, rnd41() & 41'h0FF_FFFF_FFFF, rnd41());
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         hit = !g_ch[0].cs_n;
      end
      if (!hit) fail_now("frame_start_timeout");
      repeat (60) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midreset");
      void'(g_ch[0].exp_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("reset_hold_rd_en", g_ch[0].rd_en, 0);
         chk("reset_hold_busy", g_ch[0].busy, 0);
      end
      #2 rst_n = 1'b1;
      wait_drain("drain_after_reset");

      chk("pops_ch0", g_ch[0].pops, g_ch[0].pushes);
      chk("pops_ch1", g_ch[1].pops, g_ch[1].pushes);
      chk("fifo_empty_end", g_ch[0].fe, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
